// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and the receive state encoding.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE  = 2'b00;
  localparam logic [1:0] PARITY_ODD   = 2'b01;
  localparam logic [1:0] PARITY_EVEN  = 2'b10;
  localparam logic [1:0] PARITY_NONE2 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for the serial line, idling high through reset.
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_primed
);

  logic [STAGES-1:0] r_sync;
  logic [STAGES-1:0] r_fill;

  // o_primed marks when o_q reflects the real line, not the reset value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_fill <= {r_fill[STAGES-2:0], 1'b1};
    end
  end

  assign o_q      = r_sync[STAGES-1];
  assign o_primed = r_fill[STAGES-1];

endmodule

// File: rtl/sipo_rx.sv
// UART receive deserializer: oversampled mid-bit sampling, parity and
// stop checks, parallel payload with a one-cycle done pulse.
module sipo_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  baud_clk,
  input  logic                  reset_n,
  input  logic                  data_rx,
  input  logic [1:0]            parity_type,
  output logic [DATA_WIDTH-1:0] data_parll,
  output logic                  active_flag,
  output logic                  done_flag,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  logic w_rx;
  logic w_primed;

  rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (baud_clk),
    .rst_n   (reset_n),
    .i_d     (data_rx),
    .o_q     (w_rx),
    .o_primed(w_primed)
  );

  rx_state_e             r_state, w_state_nx;
  logic [TW-1:0]         r_tick, w_tick_nx;
  logic [BW-1:0]         r_bit, w_bit_nx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nx;
  logic [1:0]            r_ptype, w_ptype_nx;
  logic                  r_pcalc, w_pcalc_nx;
  logic                  r_armed, w_armed_nx;
  logic [DATA_WIDTH-1:0] r_data, w_data_nx;
  logic                  r_perr, w_perr_nx;
  logic                  r_serr, w_serr_nx;
  logic                  r_done, w_done_nx;
  logic                  r_active, w_active_nx;
  logic                  w_has_par;

  assign w_has_par = (r_ptype == PARITY_ODD) ||
                     (r_ptype == PARITY_EVEN);

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_tick   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_ptype  <= PARITY_NONE;
      r_pcalc  <= 1'b0;
      r_armed  <= 1'b0;
      r_data   <= '0;
      r_perr   <= 1'b0;
      r_serr   <= 1'b0;
      r_done   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tick   <= w_tick_nx;
      r_bit    <= w_bit_nx;
      r_shift  <= w_shift_nx;
      r_ptype  <= w_ptype_nx;
      r_pcalc  <= w_pcalc_nx;
      r_armed  <= w_armed_nx;
      r_data   <= w_data_nx;
      r_perr   <= w_perr_nx;
      r_serr   <= w_serr_nx;
      r_done   <= w_done_nx;
      r_active <= w_active_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_tick_nx   = r_tick + TW'(1);
    w_bit_nx    = r_bit;
    w_shift_nx  = r_shift;
    w_ptype_nx  = r_ptype;
    w_pcalc_nx  = r_pcalc;
    w_armed_nx  = r_armed;
    w_data_nx   = r_data;
    w_perr_nx   = r_perr;
    w_serr_nx   = r_serr;
    w_done_nx   = 1'b0;
    w_active_nx = r_active;
    unique case (r_state)
      IDLE: begin
        w_tick_nx = '0;
        if (w_primed && w_rx) w_armed_nx = 1'b1;
        if (r_armed && !w_rx) begin
          w_state_nx  = START;
          w_active_nx = 1'b1;
        end
      end
      START: begin
        if (r_tick == T_HALF) begin
          w_tick_nx = '0;
          if (!w_rx) begin
            w_state_nx = DATA;
            w_bit_nx   = '0;
            w_ptype_nx = parity_type;
            w_pcalc_nx = 1'b0;
          end else begin
            w_state_nx  = IDLE;
            w_active_nx = 1'b0;
          end
        end
      end
      DATA: begin
        if (r_tick == T_LAST) begin
          w_tick_nx  = '0;
          w_shift_nx = {w_rx, r_shift[DATA_WIDTH-1:1]};
          w_bit_nx   = r_bit + BW'(1);
          if (r_bit == B_LAST)
            w_state_nx = w_has_par ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (r_tick == T_LAST) begin
          w_tick_nx  = '0;
          w_state_nx = STOP;
          if (r_ptype == PARITY_ODD)
            w_pcalc_nx = ~(^{r_shift, w_rx});
          else
            w_pcalc_nx = ^{r_shift, w_rx};
        end
      end
      STOP: begin
        if (r_tick == T_LAST) begin
          w_tick_nx   = '0;
          w_state_nx  = DONE;
          w_data_nx   = r_shift;
          w_serr_nx   = ~w_rx;
          w_perr_nx   = r_pcalc;
          w_done_nx   = 1'b1;
          w_active_nx = 1'b0;
          w_armed_nx  = 1'b0;
        end
      end
      DONE: begin
        w_tick_nx  = '0;
        w_state_nx = IDLE;
      end
      default: begin
        w_tick_nx  = '0;
        w_state_nx = IDLE;
      end
    endcase
  end

  assign data_parll   = r_data;
  assign active_flag  = r_active;
  assign done_flag    = r_done;
  assign parity_error = r_perr;
  assign stop_error   = r_serr;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed frames into sipo_rx, checked against a frame-level model.
module tb_sipo_rx;

  localparam int DW = 8;
  localparam int OS = 16;
  localparam int SS = 2;

  logic          baud_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          data_rx = 1'b1;
  logic [1:0]    parity_type = 2'b00;
  logic [DW-1:0] data_parll;
  logic          active_flag;
  logic          done_flag;
  logic          parity_error;
  logic          stop_error;

  sipo_rx #(
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(SS)
  ) dut (
    .baud_clk    (baud_clk),
    .reset_n     (reset_n),
    .data_rx     (data_rx),
    .parity_type (parity_type),
    .data_parll  (data_parll),
    .active_flag (active_flag),
    .done_flag   (done_flag),
    .parity_error(parity_error),
    .stop_error  (stop_error)
  );

  always #5 baud_clk = ~baud_clk;

  int cyc = 0;
  always @(posedge baud_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          se;
    int            dc;
  } exp_t;

  exp_t q[$];
  int vec = 0;
  int miss = 0;
  logic [DW-1:0] h_d = '0;
  logic h_pe = 1'b0;
  logic h_se = 1'b0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    vec++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Compare process: every cycle, outputs either hold or match a frame.
  always @(posedge baud_clk) begin
    exp_t e;
    #1;
    if (!reset_n) begin
      chk("rst_outs",
          {data_parll, active_flag, done_flag,
           parity_error, stop_error}, '0);
      h_d  = '0;
      h_pe = 1'b0;
      h_se = 1'b0;
    end else if (done_flag) begin
      chk("done_one_cycle", prev_done, 0);
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        chk("data", data_parll, e.d);
        chk("parity_err", parity_error, e.pe);
        chk("stop_err", stop_error, e.se);
        chk("latency",
            (cyc >= e.dc - 1) && (cyc <= e.dc + 1), 1);
        h_d  = e.d;
        h_pe = e.pe;
        h_se = e.se;
      end
    end else begin
      chk("hold",
          {data_parll, parity_error, stop_error},
          {h_d, h_pe, h_se});
    end
    prev_done = done_flag;
  end

  task automatic bitout(input logic b, input int n);
    data_rx = b;
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic send(input logic [DW-1:0] d,
                      input logic [1:0]    pt,
                      input logic          p,
                      input logic          stopb);
    exp_t e;
    int   np;
    int   ones;
    np   = (pt == 2'b01 || pt == 2'b10) ? 1 : 0;
    ones = $countones(d) + int'(p);
    e.d  = d;
    e.pe = (pt == 2'b01) ? (ones % 2 == 0) :
           (pt == 2'b10) ? (ones % 2 == 1) : 1'b0;
    e.se = ~stopb;
    e.dc = cyc + (1 + DW + np) * OS + OS / 2 + SS + 1;
    q.push_back(e);
    parity_type = pt;
    bitout(1'b0, OS);
    parity_type = ~pt;
    for (int i = 0; i < DW; i++) bitout(d[i], OS);
    if (np == 1) bitout(p, OS);
    bitout(stopb, OS);
  endtask

  initial begin
    @(negedge baud_clk);
    for (int i = 0; i < 20; i++) begin
      data_rx = ~data_rx;
      @(negedge baud_clk);
    end
    chk("rst_active", active_flag, 0);
    chk("rst_data", data_parll, 0);
    data_rx = 1'b1;
    @(negedge baud_clk);
    reset_n = 1'b1;
    bitout(1'b1, 2 * OS);
    chk("idle_active", active_flag, 0);

    send(8'h4A, 2'b00, 1'b0, 1'b1);
    bitout(1'b1, 2 * OS);
    chk("4A_none_data", data_parll, 8'h4A);
    chk("4A_none_flags", {parity_error, stop_error}, 0);

    send(8'h4A, 2'b01, 1'b0, 1'b1);
    bitout(1'b1, 2 * OS);
    chk("4A_odd_p0", parity_error, 0);

    send(8'h4A, 2'b01, 1'b1, 1'b1);
    bitout(1'b1, 2 * OS);
    chk("4A_odd_p1", parity_error, 1);

    send(8'h5A, 2'b10, 1'b0, 1'b1);
    bitout(1'b1, 2 * OS);
    chk("5A_even_data", data_parll, 8'h5A);
    chk("5A_even_p0", parity_error, 0);

    bitout(1'b0, 4);
    chk("glitch_active_on", active_flag, 1);
    bitout(1'b1, 12);
    chk("glitch_active_off", active_flag, 0);
    bitout(1'b1, 2 * OS);
    chk("glitch_data_kept", data_parll, 8'h5A);

    send(8'hA5, 2'b00, 1'b0, 1'b0);
    bitout(1'b0, 3 * OS);
    chk("break_no_active", active_flag, 0);
    chk("A5_data", data_parll, 8'hA5);
    chk("A5_stop_err", stop_error, 1);
    bitout(1'b1, 2 * OS);

    bitout(1'b0, OS + 3 * OS + OS / 2);
    reset_n = 1'b0;
    bitout(1'b0, 2);
    chk("midrst_outs",
        {data_parll, active_flag, stop_error}, 0);
    reset_n = 1'b1;
    bitout(1'b0, 2 * OS);
    chk("midrst_idle", active_flag, 0);
    bitout(1'b1, 2 * OS);

    send(8'h3C, 2'b10, 1'b0, 1'b1);
    bitout(1'b1, 2 * OS);
    chk("3C_data", data_parll, 8'h3C);
    chk("3C_flags", {parity_error, stop_error}, 0);

    chk("frames_pending", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, miss);
    $finish;
  end

endmodule
